// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: parity modes,
// receiver FSM states and the FIFO word width helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // A FIFO word carries the data bits plus the frame and parity error flags.
   function automatic int word_width(input int data_bits);
      return data_bits + 2;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle; a pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr];

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: storage is reset so the head word reads as zero, never X, when empty.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + AW'(1);
         end
         if (do_pop) rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, start-bit glitch rejection,
// per-word error flags and a show-ahead receive FIFO with overrun detection.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10416,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rx_serial_i,
   output logic                         m_valid_o,
   input  logic                         m_ready_i,
   output logic [DATA_BITS-1:0]         m_data_o,
   output logic                         m_frame_err_o,
   output logic                         m_parity_err_o,
   output logic                         overrun_o,
   input  logic                         clr_overrun_i,
   output logic [$clog2(FIFO_DEPTH):0]  level_o,
   output logic                         busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam int WW = word_width(DATA_BITS);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   logic                 sync1;
   logic                 rxs;
   rx_state_t            state, state_next;
   logic [CW-1:0]        cnt, cnt_next;
   logic [BW-1:0]        bit_cnt, bit_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic                 par_err, par_next;
   logic                 frame_err, fe_next;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic [WW-1:0]        head;

   // Two-flop synchroniser, reset high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so each flop captures its pre-edge input.
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx_serial_i;
         rxs   <= sync1;
      end
   end

   // Receiver state register and its datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         bit_cnt   <= bit_next;
         shift     <= shift_next;
         par_err   <= par_next;
         frame_err <= fe_next;
      end
   end

   // Next-state logic: every sample is taken when the clock counter hits zero.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      state_next = state;
      cnt_next   = cnt;
      bit_next   = bit_cnt;
      shift_next = shift;
      par_next   = par_err;
      fe_next    = frame_err;
      push       = 1'b0;

      if (state != ST_IDLE && cnt != '0) cnt_next = cnt - CW'(1);

      case (state)
         ST_IDLE: begin
            if (!rxs) begin
               state_next = ST_START;
               cnt_next   = HALF;
            end
         end
         ST_START: begin
            if (cnt == '0) begin
               if (rxs) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_DATA;
                  cnt_next   = FULL;
                  bit_next   = '0;
                  par_next   = 1'b0;
                  fe_next    = 1'b0;
               end
            end
         end
         ST_DATA: begin
            if (cnt == '0) begin
               cnt_next   = FULL;
               shift_next = {rxs, shift[DATA_BITS-1:1]};
               bit_next   = bit_cnt + BW'(1);
               if (bit_cnt == BW'(DATA_BITS - 1)) begin
                  bit_next   = '0;
                  state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (cnt == '0) begin
               cnt_next   = FULL;
               par_next   = (PARITY == PAR_ODD) ? ~(^shift ^ rxs) : (^shift ^ rxs);
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt == '0) begin
               cnt_next = FULL;
               fe_next  = frame_err | ~rxs;
               bit_next = bit_cnt + BW'(1);
               if (bit_cnt == BW'(STOP_BITS - 1)) begin
                  bit_next   = '0;
                  push       = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign pop = m_valid_o & m_ready_i;

   sync_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata ({par_err, fe_next, shift_next}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level_o)
   );

   // Sticky overrun flag; a new drop in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (!rst_n)                     overrun_o <= 1'b0;
      else if (push & full & ~pop)    overrun_o <= 1'b1;
      else if (clr_overrun_i)         overrun_o <= 1'b0;
   end

   assign m_valid_o      = ~empty;
   assign m_data_o       = head[DATA_BITS-1:0];
   assign m_frame_err_o  = head[DATA_BITS];
   assign m_parity_err_o = head[DATA_BITS+1];
   assign busy_o         = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and an 8E2 instance share clock, reset and
// handshake inputs. Expected words come from a sample-point model that decodes
// the recorded pin waveform using the frame timing rules.
module tb_uart_rx_fifo;

   localparam int C = 16;
   localparam int H = C / 2;
   localparam int D = 4;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       pe;
      int         idx;
   } word_t;

   logic       clk;
   logic       rst_n;
   logic       rx_n, rx_e;
   logic       ready;
   logic       clr;
   logic       v_n, v_e;
   logic [7:0] d_n, d_e;
   logic       fe_n, fe_e, pe_n, pe_e, ov_n, ov_e, busy_n, busy_e;
   logic [2:0] lv_n, lv_e;

   int    checks = 0;
   int    errors = 0;
   int    t0;
   bit    log_n[$];
   bit    log_e[$];
   word_t got_n[$];
   word_t got_e[$];
   word_t exp_q[$];
   word_t mon_n, mon_e;

   uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(D)) dut_n (
      .clk(clk), .rst_n(rst_n), .rx_serial_i(rx_n), .m_valid_o(v_n), .m_ready_i(ready),
      .m_data_o(d_n), .m_frame_err_o(fe_n), .m_parity_err_o(pe_n), .overrun_o(ov_n),
      .clr_overrun_i(clr), .level_o(lv_n), .busy_o(busy_n));

   uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(D)) dut_e (
      .clk(clk), .rst_n(rst_n), .rx_serial_i(rx_e), .m_valid_o(v_e), .m_ready_i(ready),
      .m_data_o(d_e), .m_frame_err_o(fe_e), .m_parity_err_o(pe_e), .overrun_o(ov_e),
      .clr_overrun_i(clr), .level_o(lv_e), .busy_o(busy_e));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record the pin value seen at every active edge since reset release.
   always @(posedge clk) begin
      if (!rst_n) begin
         log_n.delete();
         log_e.delete();
      end else begin
         log_n.push_back(rx_n);
         log_e.push_back(rx_e);
      end
   end

   // Record every accepted word with the index of the edge preceding it.
   always @(negedge clk) begin
      if (rst_n && v_n && ready) begin
         mon_n = '{d_n, fe_n, pe_n, log_n.size() - 1};
         got_n.push_back(mon_n);
      end
      if (rst_n && v_e && ready) begin
         mon_e = '{d_e, fe_e, pe_e, log_e.size() - 1};
         got_e.push_back(mon_e);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input bit sel, input bit v, input int cycles);
      if (sel) rx_e = v;
      else     rx_n = v;
      tick(cycles);
   endtask

   task automatic idle(input bit sel, input int bits);
      drive_bit(sel, 1'b1, bits * C);
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      rx_n  = 1'b1;
      rx_e  = 1'b1;
      got_n.delete();
      got_e.delete();
      tick(cycles);
      rst_n = 1'b1;
   endtask

   // Transmit one frame; the 8E2 line gets an even parity bit, optionally inverted.
   task automatic send_frame(input bit sel, input logic [7:0] d, input bit bad_par,
                             input bit stop_low, output int t_start);
      t_start = sel ? log_e.size() : log_n.size();
      drive_bit(sel, 1'b0, C);
      for (int k = 0; k < 8; k++) drive_bit(sel, d[k], C);
      if (sel) drive_bit(sel, (^d) ^ bad_par, C);
      for (int s = 0; s < (sel ? 2 : 1); s++) drive_bit(sel, ~stop_low, C);
      if (sel) rx_e = 1'b1;
      else     rx_n = 1'b1;
   endtask

   function automatic bit pin(input bit sel, input int j);
      if (j < 0) return 1'b1;
      if (sel) return (j < log_e.size()) ? log_e[j] : 1'b1;
      return (j < log_n.size()) ? log_n[j] : 1'b1;
   endfunction

   // Decode the recorded waveform: bit k of a frame whose line fell at t0 is
   // judged from the pin at t0+1+H+k*C and the word appears after edge
   // t0+3+H+(N-1)*C; the search for the next start resumes two cycles earlier.
   task automatic model_decode(input bit sel);
      int    j, lim, nb, par, stops, push_at;
      bit    b, x, fe, pe;
      logic [7:0] d;
      word_t w;
      par   = sel ? 2 : 0;
      stops = sel ? 2 : 1;
      nb    = 1 + 8 + ((par != 0) ? 1 : 0) + stops;
      lim   = sel ? log_e.size() : log_n.size();
      exp_q.delete();
      j = 0;
      while (j < lim) begin
         if (pin(sel, j)) begin
            j++;
         end else if (pin(sel, j + 1 + H)) begin
            j = j + 2 + H;
         end else begin
            push_at = j + 3 + H + (nb - 1) * C;
            if (push_at >= lim) break;
            d = '0;
            x = 1'b0;
            for (int k = 0; k < 8; k++) begin
               b    = pin(sel, j + 1 + H + (k + 1) * C);
               d[k] = b;
               x    = x ^ b;
            end
            pe = 1'b0;
            if (par != 0) begin
               x  = x ^ pin(sel, j + 1 + H + 9 * C);
               pe = (par == 1) ? ~x : x;
            end
            fe = 1'b0;
            for (int s = 0; s < stops; s++)
               if (!pin(sel, j + 1 + H + (nb - stops + s) * C)) fe = 1'b1;
            w = '{d, fe, pe, push_at};
            exp_q.push_back(w);
            j = push_at - 1;
         end
      end
   endtask

   task automatic compare_words(input bit sel, input string tag);
      int    n;
      word_t g;
      n = sel ? got_e.size() : got_n.size();
      check({tag, "_count"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         g = sel ? got_e[i] : got_n[i];
         check({tag, "_data"}, g.data, exp_q[i].data);
         check({tag, "_fe"},   g.fe,   exp_q[i].fe);
         check({tag, "_pe"},   g.pe,   exp_q[i].pe);
         check({tag, "_time"}, g.idx,  exp_q[i].idx);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, {v_e, v_n}, 2'b00);
      check({tag, "_data"},  {d_e, d_n}, 16'h0000);
      check({tag, "_fe"},    {fe_e, fe_n}, 2'b00);
      check({tag, "_pe"},    {pe_e, pe_n}, 2'b00);
      check({tag, "_ovr"},   {ov_e, ov_n}, 2'b00);
      check({tag, "_level"}, {lv_e, lv_n}, 6'd0);
      check({tag, "_busy"},  {busy_e, busy_n}, 2'b00);
   endtask

   initial begin
      bit       busy_seen;
      bit       bad_par, stop_low;
      int       gap;
      int       got_size;
      logic [7:0] d;

      rst_n = 1'b0;
      rx_n  = 1'b1;
      rx_e  = 1'b1;
      ready = 1'b1;
      clr   = 1'b0;
      do_reset(3);
      check_reset_outputs("reset");

      // 8N1 basic: single word, exact valid timing, one-cycle valid pulse.
      send_frame(1'b0, 8'h9D, 1'b0, 1'b0, t0);
      idle(1'b0, 3);
      check("basic_count", got_n.size(), 1);
      if (got_n.size() > 0) begin
         check("basic_data", got_n[0].data, 8'h9D);
         check("basic_flags", {got_n[0].pe, got_n[0].fe}, 2'b00);
         check("basic_valid_time", got_n[0].idx, t0 + 3 + H + 9 * C);
      end
      model_decode(1'b0);
      compare_words(1'b0, "basic");

      // Even parity with two stop bits: good parity then inverted parity.
      send_frame(1'b1, 8'h17, 1'b0, 1'b0, t0);
      send_frame(1'b1, 8'h17, 1'b1, 1'b0, t0);
      idle(1'b1, 3);
      check("par_count", got_e.size(), 2);
      if (got_e.size() >= 2) begin
         check("par_good_pe", got_e[0].pe, 1'b0);
         check("par_bad_pe", got_e[1].pe, 1'b1);
         check("par_bad_data", got_e[1].data, 8'h17);
         check("par_bad_fe", got_e[1].fe, 1'b0);
      end
      model_decode(1'b1);
      compare_words(1'b1, "par");

      // Framing error followed by a 20-bit break.
      do_reset(2);
      send_frame(1'b0, 8'hA5, 1'b0, 1'b1, t0);
      idle(1'b0, 3);
      drive_bit(1'b0, 1'b0, 20 * C);
      idle(1'b0, 40);
      got_size = got_n.size();
      check("brk_min_count", got_size >= 2, 1'b1);
      if (got_size >= 2) begin
         check("frm_word", {got_n[0].fe, got_n[0].data}, 9'h1A5);
         check("brk_word", {got_n[1].fe, got_n[1].data}, 9'h100);
      end
      model_decode(1'b0);
      compare_words(1'b0, "brk");

      // Glitch rejection: a 3-cycle low pulse on an idle line.
      do_reset(2);
      idle(1'b0, 2);
      drive_bit(1'b0, 1'b0, 3);
      rx_n = 1'b1;
      busy_seen = 1'b0;
      for (int i = 0; i < 3 * C; i++) begin
         busy_seen = busy_seen | busy_n;
         tick(1);
      end
      check("glitch_busy_seen", busy_seen, 1'b1);
      check("glitch_busy_end", busy_n, 1'b0);
      check("glitch_level", lv_n, 3'd0);
      model_decode(1'b0);
      compare_words(1'b0, "glitch");

      // Overrun: five words into a four-deep FIFO with the consumer stalled.
      do_reset(2);
      ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0, t0);
      idle(1'b0, 3);
      model_decode(1'b0);
      check("ovr_level", lv_n, (exp_q.size() > D) ? D : exp_q.size());
      check("ovr_flag", ov_n, exp_q.size() > D);
      check("ovr_head", d_n, 8'h01);
      ready = 1'b1;
      tick(8);
      check("ovr_drain_count", got_n.size(), D);
      for (int i = 0; i < got_n.size() && i < D && i < exp_q.size(); i++)
         check("ovr_drain_data", got_n[i].data, exp_q[i].data);
      check("ovr_drained_level", lv_n, 3'd0);
      check("ovr_sticky", ov_n, 1'b1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("ovr_cleared", ov_n, 1'b0);

      // Reset in the middle of the data bits with two words queued.
      do_reset(2);
      ready = 1'b0;
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, t0);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, t0);
      idle(1'b0, 1);
      check("mid_level_before", lv_n, 3'd2);
      drive_bit(1'b0, 1'b0, C);
      drive_bit(1'b0, 1'b0, C);
      drive_bit(1'b0, 1'b0, C / 2);
      check("mid_busy_before", busy_n, 1'b1);
      do_reset(1);
      check_reset_outputs("mid_reset");
      ready = 1'b1;
      idle(1'b0, 2);
      send_frame(1'b0, 8'h06, 1'b0, 1'b0, t0);
      idle(1'b0, 3);
      check("mid_count", got_n.size(), 1);
      if (got_n.size() > 0) check("mid_word", {got_n[0].pe, got_n[0].fe, got_n[0].data}, 10'h006);
      model_decode(1'b0);
      compare_words(1'b0, "mid");

      // Randomised frames with occasional errors and back-to-back spacing.
      for (int sel = 0; sel < 2; sel++) begin
         do_reset(2);
         ready = 1'b1;
         for (int f = 0; f < 12; f++) begin
            d        = 8'($urandom);
            bad_par  = (sel == 1) && ($urandom_range(0, 3) == 0);
            stop_low = ($urandom_range(0, 5) == 0);
            gap      = $urandom_range(0, 2);
            send_frame(sel[0], d, bad_par, stop_low, t0);
            if (gap > 0) idle(sel[0], gap);
         end
         idle(sel[0], 40);
         model_decode(sel[0]);
         compare_words(sel[0], sel ? "rand_e" : "rand_n");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a buffered output and valid/ready handshake. It replaces the bare `uart_rx` in the top level, which exposes only a one-cycle `dv` pulse and a byte. This block adds:
- configurable frame format (data bits, parity, stop bits);
- input synchronisation and start-bit glitch rejection;
- per-word error flags;
- a receive FIFO with overrun detection.

It sits between the `uart_rx` pin and the AXI/GPIO side of the design.

## Interface
- `CLKS_PER_BIT`, 10416: clock cycles per bit, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: number of words, power of two, ≥ 2.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_serial_i`  in  1  asynchronous serial line, idles high.
- `m_valid_o`  out  1  FIFO head word valid.
- `m_ready_i`  in  1  consumer accepts the head word.
- `m_data_o`  out  DATA_BITS  head word data.
- `m_frame_err_o`  out  1  head word had a stop bit sampled low.
- `m_parity_err_o`  out  1  head word failed the parity check; always 0 when PARITY = 0.
- `overrun_o`  out  1  sticky flag: a received word was dropped because the FIFO was full.
- `clr_overrun_i`  in  1  clears `overrun_o`.
- `level_o`  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `busy_o`  out  1  receiver FSM is not in IDLE.

## Operation
- **Input synchronisation:** `rx_serial_i` passes through a 2-FF synchroniser; both flops reset to 1. All sampling below uses the synchronised signal `rxs`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. A bit counter and a clock counter of width clog2(CLKS_PER_BIT) are used.
- **IDLE:** when `rxs` = 0, go to START and load the clock counter with H = CLKS_PER_BIT/2 (integer division).
- **START:** at the H-point, re-sample `rxs`.
  - `rxs` = 1: treat as a glitch and return to IDLE. Nothing is pushed.
  - `rxs` = 0: go to DATA. Every later sample is taken CLKS_PER_BIT cycles after the previous one.
- **DATA:** shift DATA_BITS samples in LSB first. Then go to PARITY if PARITY ≠ 0, otherwise to STOP.
- **PARITY:** take one sample.
  - Odd parity error: XOR of data and parity bit = 0.
  - Even parity error: XOR of data and parity bit = 1.
- **STOP:** take STOP_BITS samples. The frame error flag is set if any stop sample is 0. This includes a break, where all bits are zero.
- **Push:** on the final stop sample, push {parity_err, frame_err, data} into the FIFO and return to IDLE in the same cycle. The receiver then looks for the next start edge immediately, so back-to-back frames are supported. Words with errors are still pushed.
- **FIFO behaviour:** show-ahead. `m_*` outputs present the head word whenever `m_valid_o` = 1.
  - A pop occurs on `m_valid_o & m_ready_i`.
  - A push while full is dropped and sets `overrun_o`, unless a pop occurs in the same cycle, in which case the push succeeds.
  - Pop while empty is ignored.
  - Simultaneous push and pop leaves `level_o` unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Overrun flag:** `clr_overrun_i` clears `overrun_o`. If a clear and a new overrun occur in the same cycle, the set wins.
- **Output data when empty:** `m_data_o` and the error flags are don't-care when `m_valid_o` = 0. They must not be X after reset, which requires resetting the FIFO storage or gating to 0.

## Timing
- **Reset values:** `m_valid_o`=0, `m_data_o`=0, `m_frame_err_o`=0, `m_parity_err_o`=0, `overrun_o`=0, `level_o`=0, `busy_o`=0. FSM in IDLE, synchroniser at 1, pointers at 0.
- **Reset mid-frame:** abandons the frame, empties the FIFO, and pushes nothing.
- **Sample points:** let t0 be the first cycle in which `rx_serial_i` = 0 at the pin.
  - `rxs` falls at t0+2, and START is entered at t0+3.
  - Bit k (k = 0 is the start bit) is sampled at t0+3+H+k·CLKS_PER_BIT.
- **Push latency:** N = 1+DATA_BITS+(PARITY≠0)+STOP_BITS. The push occurs at the last stop sample, t0+3+H+(N−1)·CLKS_PER_BIT. `m_valid_o` is high from the following cycle when the FIFO was empty.
- **Pop:** `m_valid_o`/`level_o` update the cycle after the handshake, and the next head word is visible in that same cycle.
- **`busy_o`:** high from START entry until the push cycle inclusive.

## Structure
- **Shared package:** `uart_pkg` holds the parity mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), the FSM state enum, and a function for the FIFO word width, DATA_BITS+2.
- **Sub-module:** `sync_fifo` (parameters WIDTH, DEPTH; ports push, pop, full, empty, level). The receiver FSM and synchroniser stay in `uart_rx_fifo`.

## Test plan
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- **8N1 basic:** send 0x9D with `m_ready_i`=1 → `m_data_o`=0x9D with no error flags. `m_valid_o` rises exactly at t0+3+8+9·16+1 and stays high 1 cycle.
- **Even parity:** with PARITY=2, send 0x17 with a correct parity bit (0), then 0x17 with parity 1 → first word has `m_parity_err_o`=0, second has `m_parity_err_o`=1 with data 0x17.
- **Framing and break:** send 0xA5 with the stop bit held low, then a 20-bit all-zero break → first word is 0xA5 with `m_frame_err_o`=1, then word 0x00 with `m_frame_err_o`=1. No spurious extra word after the line returns high.
- **Glitch rejection:** a 3-cycle low pulse on an idle line → `busy_o` pulses, no push, `level_o` stays 0.
- **Overrun:** with `m_ready_i`=0, send 0x01..0x05 → `level_o`=4 and `overrun_o`=1. Draining returns 0x01..0x04, and 0x05 is lost. Pulsing `clr_overrun_i` clears the flag.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during the data bits of 0x3C with 2 words queued → all outputs at reset values. A subsequent 0x06 is received cleanly as the only word.
